// File: rtl/micro_sequencer.sv
// Microprogrammed control sequencer: 16-entry loadable microprogram with a
// FETCH/EXEC cadence, flag capture and conditional microbranching.
module micro_sequencer #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [23:0]   load_data,
    input  logic          z,
    input  logic          s,
    input  logic          v,
    input  logic          c,
    output logic [2:0]    A,
    output logic [2:0]    B,
    output logic [2:0]    D,
    output logic [3:0]    F,
    output logic [2:0]    H,
    output logic          we,
    output logic [AW-1:0] upc,
    output logic          busy,
    output logic          halted
);

    // state | meaning
    // IDLE  | after reset, waiting for start; microprogram loadable
    // FETCH | ir <- mem[upc]
    // EXEC  | control word driven from ir; flags/upc updated at closing edge
    // HALT  | stopped by HALT op; loadable, start restarts at 0
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JS   = 3'b011;
    localparam logic [2:0] OP_JV   = 3'b100;
    localparam logic [2:0] OP_JC   = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    state_t        state_q, state_d;
    logic [AW-1:0] upc_q, upc_d;
    logic [23:0]   ir_q, ir_d;
    logic [3:0]    flags_q, flags_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic          mem_we;
    logic          take;

    logic [23:0]   mem_q [0:(2**AW)-1];

    logic [2:0]    ir_op;
    logic [AW-1:0] ir_tgt;
    logic          ir_we;

    assign ir_op  = ir_q[23:21];
    assign ir_tgt = ir_q[17 +: AW];
    assign ir_we  = ir_q[16];

    // Branches test the stored flags {z,s,v,c}, never the live inputs.
    always_comb begin
        take = 1'b0;
        case (ir_op)
            OP_JMP:  take = 1'b1;
            OP_JZ:   take = flags_q[3];
            OP_JS:   take = flags_q[2];
            OP_JV:   take = flags_q[1];
            OP_JC:   take = flags_q[0];
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_we = load_en;
                if (start) begin
                    state_d = ST_FETCH;
                    upc_d   = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = mem_q[upc_q];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ir_we) begin
                    flags_d = {z, s, v, c};
                end
                if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    upc_d   = take ? ir_tgt : upc_q + 1'b1;
                end
            end
            ST_HALT: begin
                mem_we = load_en;
                if (start) begin
                    state_d = ST_FETCH;
                    upc_d   = '0;
                    flags_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            upc_q    <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc_q    <= upc_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Microprogram store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        A  = 3'b000;
        B  = 3'b000;
        D  = 3'b000;
        F  = 4'b0000;
        H  = 3'b000;
        we = 1'b0;
        if (state_q == ST_EXEC) begin
            A  = ir_q[15:13];
            B  = ir_q[12:10];
            D  = ir_q[9:7];
            F  = ir_q[6:3];
            H  = ir_q[2:0];
            we = ir_we;
        end
    end

    assign upc    = upc_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: sequencing, branching, wrap, load
// gating and mid-instruction reset.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [23:0] load_data;
    logic        z, s, v, c;
    logic [2:0]  A, B, D, H;
    logic [3:0]  F;
    logic        we;
    logic [3:0]  upc;
    logic        busy, halted;

    int n_assert = 0;
    int n_fail   = 0;

    micro_sequencer #(.AW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .z(z), .s(s), .v(v), .c(c),
        .A(A), .B(B), .D(D), .F(F), .H(H), .we(we),
        .upc(upc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, JZ = 3'd2, JC = 3'd5, HLT = 3'd6;

    function automatic logic [23:0] mw(input logic [2:0] op, input logic [3:0] tgt,
                                       input logic w, input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d, input logic [3:0] f, input logic [2:0] h);
        return {op, tgt, w, a, b, d, f, h};
    endfunction

    function automatic logic [16:0] cw(input logic w, input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d, input logic [3:0] f, input logic [2:0] h);
        return {w, a, b, d, f, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [23:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [16:0] ctl;
    assign ctl = {we, A, B, D, F, H};

    initial begin
        reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        z = 1'b0; s = 1'b0; v = 1'b0; c = 1'b0;
        #12;
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_upc", 32'(upc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        reset = 1'b0;
        tick();

        // basic: NEXT with control word, then HALT
        load(4'd0, mw(NEXT, 4'd0, 1'b1, 3'd1, 3'd2, 3'd3, 4'b0010, 3'd0));
        load(4'd1, mw(HLT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        chk("s1_fetch_busy", 32'(busy), 32'h1);
        chk("s1_fetch_ctl", 32'(ctl), 32'h0);
        chk("s1_fetch_upc", 32'(upc), 32'h0);
        tick();
        chk("s1_exec_ctl", 32'(ctl), 32'(cw(1'b1, 3'd1, 3'd2, 3'd3, 4'b0010, 3'd0)));
        tick();
        chk("s1_fetch2_upc", 32'(upc), 32'h1);
        chk("s1_fetch2_we", 32'(we), 32'h0);
        tick();
        chk("s1_exec2_we", 32'(we), 32'h0);
        chk("s1_exec2_busy", 32'(busy), 32'h1);
        tick();
        chk("s1_halted", 32'(halted), 32'h1);
        chk("s1_busy", 32'(busy), 32'h0);
        chk("s1_upc", 32'(upc), 32'h1);
        chk("s1_halt_ctl", 32'(ctl), 32'h0);

        // JZ taken on captured z=1
        z = 1'b1;
        load(4'd0, mw(NEXT, 4'd0, 1'b1, 3'd1, 3'd2, 3'd3, 4'b0010, 3'd0));
        load(4'd1, mw(JZ, 4'd5, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        load(4'd5, mw(HLT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        chk("s2a_upc0", 32'(upc), 32'h0);
        tick(); tick();
        chk("s2a_upc1", 32'(upc), 32'h1);
        tick(); tick();
        chk("s2a_upc5", 32'(upc), 32'h5);
        tick(); tick();
        chk("s2a_halted", 32'(halted), 32'h1);
        chk("s2a_upc", 32'(upc), 32'h5);

        // JZ not taken on captured z=0
        z = 1'b0;
        load(4'd2, mw(HLT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        chk("s2b_upc0", 32'(upc), 32'h0);
        tick(); tick();
        chk("s2b_upc1", 32'(upc), 32'h1);
        tick(); tick();
        chk("s2b_upc2", 32'(upc), 32'h2);
        tick(); tick();
        chk("s2b_halted", 32'(halted), 32'h1);

        // JC: live c=1 but nothing captured it
        c = 1'b1;
        load(4'd0, mw(NEXT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        load(4'd1, mw(JC, 4'd5, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        tick(); tick();
        chk("s3_upc1", 32'(upc), 32'h1);
        tick(); tick();
        chk("s3_upc2", 32'(upc), 32'h2);
        tick(); tick();
        chk("s3_halted", 32'(halted), 32'h1);
        c = 1'b0;

        // load ignored while running, honoured in HALT (with simultaneous start)
        load(4'd0, mw(NEXT, 4'd0, 1'b0, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0));
        load(4'd1, mw(HLT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        load_en = 1'b1; load_addr = 4'd0;
        load_data = mw(NEXT, 4'd0, 1'b0, 3'd7, 3'd0, 3'd0, 4'd0, 3'd0);
        tick();
        chk("s5_exec_orig", 32'(ctl), 32'(cw(1'b0, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0)));
        tick();
        load_en = 1'b0;
        tick(); tick();
        chk("s5_halted", 32'(halted), 32'h1);
        go();
        tick();
        chk("s5_rerun_orig", 32'(ctl), 32'(cw(1'b0, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0)));
        tick(); tick(); tick();
        chk("s5_halted2", 32'(halted), 32'h1);
        load_en = 1'b1; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        tick();
        chk("s5_new_word", 32'(ctl), 32'(cw(1'b0, 3'd7, 3'd0, 3'd0, 4'd0, 3'd0)));
        tick(); tick(); tick();
        chk("s5_halted3", 32'(halted), 32'h1);

        // wrap-around 15 -> 0
        load(4'd0, mw(JMP, 4'd15, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        load(4'd15, mw(NEXT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        tick(); tick();
        chk("s4_upc15", 32'(upc), 32'hF);
        tick(); tick();
        chk("s4_wrap", 32'(upc), 32'h0);
        chk("s4_busy", 32'(busy), 32'h1);

        // reset mid-EXEC with we=1
        reset = 1'b1; #1; reset = 1'b0;
        load(4'd0, mw(NEXT, 4'd0, 1'b1, 3'd1, 3'd2, 3'd3, 4'b0010, 3'd0));
        load(4'd1, mw(JZ, 4'd5, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        z = 1'b1;
        go();
        tick();
        chk("s6_exec_we", 32'(we), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("s6_rst_ctl", 32'(ctl), 32'h0);
        chk("s6_rst_busy", 32'(busy), 32'h0);
        chk("s6_rst_halted", 32'(halted), 32'h0);
        chk("s6_rst_upc", 32'(upc), 32'h0);
        tick();
        reset = 1'b0;
        load(4'd0, mw(NEXT, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0));
        go();
        chk("s6_upc0", 32'(upc), 32'h0);
        tick(); tick();
        chk("s6_upc1", 32'(upc), 32'h1);
        tick(); tick();
        chk("s6_upc2_flags0", 32'(upc), 32'h2);
        tick(); tick();
        chk("s6_halted", 32'(halted), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogrammed control sequencer that drives the control word (register selects A/B/D, ALU function F, shifter function H) of the processing unit directly downstream. It holds a loadable 16-entry microprogram, steps through it with a two-cycle FETCH/EXEC cadence, captures the ALU status flags (z, s, v, c) into a flag register, and performs conditional microbranches on them. A halt microinstruction stops sequencing until the next start.

## Interface
- AW, 4, microprogram address width; depth 2**AW entries of 24 bits.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution at address 0; sampled in IDLE and HALT only.
- load_en  in  1  microprogram write strobe; honoured in IDLE and HALT only.
- load_addr  in  AW  microprogram write address.
- load_data  in  24  microword to write.
- z, s, v, c  in  1 each  ALU status flags from the processing unit (combinational during EXEC).
- A, B, D  out  3 each  read-select A, read-select B, write-select D.
- F  out  4  ALU function select.
- H  out  3  shifter function select.
- we  out  1  register-file write enable / flag-capture qualifier.
- upc  out  AW  current microprogram counter.
- busy  out  1  high in FETCH and EXEC.
- halted  out  1  high in HALT.

## Operation
- Microword fields: [23:21] seq op, [20:17] branch target (low AW bits used), [16] we, [15:13] A, [12:10] B, [9:7] D, [6:3] F, [2:0] H.
- Seq ops: 000 NEXT; 001 JMP; 010 JZ; 011 JS; 100 JV; 101 JC; 110 HALT; 111 reserved, behaves as NEXT.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: start=1 → FETCH, upc←0. Otherwise stay.
- FETCH: ir←mem[upc]; → EXEC.
- EXEC: A/B/D/F/H/we driven from ir. At the closing edge:
  - if ir.we=1: flag register {z,s,v,c} ← inputs; else flags hold.
  - NEXT: upc←upc+1, modulo 2**AW (15 wraps to 0).
  - JMP: upc←target.
  - Jx: upc←target if the corresponding stored flag (value before this edge) is 1, else upc+1. The current instruction's own flags never affect its own branch.
  - Next state FETCH, except HALT op → HALT with upc unchanged.
- HALT: outputs idle; start=1 → FETCH, upc←0, flags cleared.
- Outside EXEC: A=B=D=000, F=0000, H=000, we=0.
- load_en in IDLE/HALT: mem[load_addr]←load_data at the edge. load_en in FETCH/EXEC is ignored (no write).
- Simultaneous load_en and start in IDLE/HALT: both take effect; the following FETCH at address 0 reads the newly written word if load_addr=0.
- Microprogram memory is not affected by reset; contents are undefined until loaded.

## Timing
- Reset (async, immediate): state IDLE, upc=0, ir=0, flags=0, all control outputs 0, we=0, busy=0, halted=0.
- Reset asserted mid-FETCH/EXEC aborts the instruction; no flag capture or upc update occurs on that edge.
- Each microinstruction: 1 FETCH cycle + 1 EXEC cycle; control word is valid for exactly the EXEC cycle.
- start sampled at edge N in IDLE → FETCH in cycle N+1, first EXEC in cycle N+2.
- Register-file write occurs on the clock edge closing EXEC when we=1 (same edge as flag capture).
- busy and halted are registered state decodes, never both high.

## Test plan
- Reset, load mem[0]=NEXT/we=1/A=1/B=2/D=3/F=0010/H=000, mem[1]=HALT; pulse start → cycle 2 shows A=1,B=2,D=3,F=0010,we=1; cycle 4 shows we=0; then halted=1, busy=0, upc=1.
- mem[0] we=1 with z=1 driven; mem[1]=JZ target 5; mem[5]=HALT → upc goes 0,1,5, halted. Repeat with z=0 → upc goes 0,1,2.
- JC with mem[0] we=0 while c=1 and the stored flag c=0 → branch not taken (only captured flags count).
- mem[15]=NEXT reached via JMP 15 → next upc=0 (wrap-around).
- During execution, pulse load_en to address 0 with new data → readback after HALT plus restart shows original word executed; same load in HALT takes effect.
- Assert reset during an EXEC with we=1 → all outputs 0 immediately, flags remain 0, state IDLE; a new start runs from upc=0.
